quadrant_view_ctrl: RTL and testbench

// - Sequencer for the VGA image viewer: owns quadrant selection (1..16) and the ROM/RAM view switch.
// - Runs the process handshake with the quadrant processor.
// - Generates the per-pixel read address for the 400x400 image memories, ahead of the beam.
// - Sits between the VGA timing block (x, y, pixel_en) and the pixel painter.
// - Drives the painter's quadrant/start inputs and the DROM/DRAM address buses.

---
 rtl/viewer_pkg.sv | 24 ++
 rtl/view_addr_gen.sv | 65 ++++++
 rtl/quadrant_view_ctrl.sv | 141 ++++++++++++++
 tb/tb_quadrant_view_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viewer_pkg.sv
// Shared types and constants for the quadrant image viewer: FSM states,
// quadrant range, default window geometry and the quadrant step helper.
package viewer_pkg;

  typedef enum logic [1:0] {BROWSE, REQ, WAIT, SHOW} view_state_t;

  localparam logic [4:0] Q_MIN = 5'd1;
  localparam logic [4:0] Q_MAX = 5'd16;

  localparam int X0_DEF       = 20;
  localparam int Y0_DEF       = 40;
  localparam int IMG_W_DEF    = 400;
  localparam int IMG_H_DEF    = 400;
  localparam int ADDR_W_DEF   = 18;
  localparam int PREFETCH_DEF = 1;
  localparam int H_TOTAL_DEF  = 800;

  // Step the quadrant number up or down with wrap 16->1 and 1->16.
  function automatic logic [4:0] q_step(input logic [4:0] q, input logic up);
    if (up) return (q == Q_MAX) ? Q_MIN : q + 5'd1;
    else    return (q == Q_MIN) ? Q_MAX : q - 5'd1;
  endfunction

endpackage

// File: rtl/view_addr_gen.sv
// Image memory read address generator: a row base stepped by IMG_W per line
// plus a column counter, leading the beam by PREFETCH pixel ticks.
module view_addr_gen
  import viewer_pkg::*;
#(
  parameter int X0       = X0_DEF,
  parameter int Y0       = Y0_DEF,
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PREFETCH = PREFETCH_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] mem_addr
);

  localparam int COL_W = $clog2(IMG_W + 1);
  localparam logic [10:0] X0_L    = 11'(X0);
  localparam logic [10:0] X_END_L = 11'(X0 + IMG_W);
  localparam logic [10:0] Y0_L    = 11'(Y0);
  localparam logic [10:0] Y_END_L = 11'(Y0 + IMG_H);
  localparam logic [10:0] HT_L    = 11'(H_TOTAL);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  logic [10:0]       xa_sum, xa, y_w;
  logic              col_in, row_in, line_start;
  logic [COL_W-1:0]  col_reg, col_eff;
  logic [ADDR_W-1:0] row_base_reg, mem_addr_reg;

  // Look-ahead column, wrapped within the line.
  assign xa_sum     = {1'b0, x} + 11'(PREFETCH);
  assign xa         = (xa_sum >= HT_L) ? xa_sum - HT_L : xa_sum;
  assign y_w        = {1'b0, y};
  assign col_in     = (xa >= X0_L) && (xa < X_END_L);
  assign row_in     = (y_w >= Y0_L) && (y_w < Y_END_L);
  assign line_start = (x == 10'd0);
  assign col_eff    = (xa == X0_L) ? '0 : col_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base_reg <= '0;
      col_reg      <= '0;
      mem_addr_reg <= '0;
    end else if (pixel_en) begin
      if (line_start && (y_w == Y0_L))
        row_base_reg <= '0;
      else if (line_start && (y_w > Y0_L) && (y_w < Y_END_L))
        row_base_reg <= row_base_reg + IMG_W_A;
      if (col_in && row_in) begin
        mem_addr_reg <= row_base_reg + ADDR_W'(col_eff);
        col_reg      <= col_eff + 1'b1;
      end else if (xa == X0_L) begin
        col_reg <= '0;
      end
    end
  end

  assign mem_addr = mem_addr_reg;

endmodule

// File: rtl/quadrant_view_ctrl.sv
// Viewer sequencer: quadrant browsing, processing handshake, frame-synchronous
// painter controls and the image memory read address.
module quadrant_view_ctrl
  import viewer_pkg::*;
#(
  parameter int X0       = X0_DEF,
  parameter int Y0       = Y0_DEF,
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PREFETCH = PREFETCH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_go,
  input  logic              proc_ack,
  input  logic              proc_done,
  output logic [4:0]        quadrant,
  output logic              start,
  output logic              proc_req,
  output logic [4:0]        proc_quadrant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy
);

  view_state_t state_reg, state_next;
  logic [4:0]  q_pend_reg, q_pend_next, proc_q_reg, proc_q_next, quadrant_reg;
  logic        start_pend_reg, start_pend_next, proc_req_reg, proc_req_next, start_reg;
  logic [2:0]  btn_s1_reg, btn_s2_reg, btn_edge;
  logic        go_ev, next_ev, prev_ev, frame_start;

  // Bit order {go, prev, next}; one event per press, go wins, then next.
  assign btn_edge = btn_s1_reg & ~btn_s2_reg;
  assign go_ev    = btn_edge[2];
  assign next_ev  = btn_edge[0] & ~btn_edge[2];
  assign prev_ev  = btn_edge[1] & ~btn_edge[2] & ~btn_edge[0];
  assign frame_start = pixel_en && (x == 10'd0) && (y == 10'd0);

  always_comb begin
    state_next      = state_reg;
    q_pend_next     = q_pend_reg;
    start_pend_next = start_pend_reg;
    proc_req_next   = proc_req_reg;
    proc_q_next     = proc_q_reg;
    case (state_reg)
      BROWSE: begin
        if (go_ev) begin
          state_next    = REQ;
          proc_req_next = 1'b1;
          proc_q_next   = q_pend_reg;
        end else if (next_ev || prev_ev) begin
          q_pend_next = q_step(q_pend_reg, next_ev);
        end
      end
      REQ: begin
        if (proc_ack) begin
          proc_req_next = 1'b0;
          if (proc_done) begin
            state_next      = SHOW;
            start_pend_next = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (proc_done) begin
          state_next      = SHOW;
          start_pend_next = 1'b1;
        end
      end
      SHOW: begin
        // Any button leaves the processed view; next/prev also step the quadrant.
        if (go_ev) begin
          state_next      = BROWSE;
          start_pend_next = 1'b0;
        end else if (next_ev || prev_ev) begin
          state_next      = BROWSE;
          start_pend_next = 1'b0;
          q_pend_next     = q_step(q_pend_reg, next_ev);
        end
      end
      default: state_next = BROWSE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= BROWSE;
      q_pend_reg     <= Q_MIN;
      start_pend_reg <= 1'b0;
      proc_req_reg   <= 1'b0;
      proc_q_reg     <= Q_MIN;
      btn_s1_reg     <= '0;
      btn_s2_reg     <= '0;
      quadrant_reg   <= Q_MIN;
      start_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      q_pend_reg     <= q_pend_next;
      start_pend_reg <= start_pend_next;
      proc_req_reg   <= proc_req_next;
      proc_q_reg     <= proc_q_next;
      btn_s1_reg     <= {btn_go, btn_prev, btn_next};
      btn_s2_reg     <= btn_s1_reg;
      if (frame_start) begin
        quadrant_reg <= q_pend_reg;
        start_reg    <= start_pend_reg;
      end
    end
  end

  assign quadrant      = quadrant_reg;
  assign start         = start_reg;
  assign proc_req      = proc_req_reg;
  assign proc_quadrant = proc_q_reg;
  assign busy          = (state_reg == REQ) || (state_reg == WAIT);

  view_addr_gen #(
    .X0       (X0),
    .Y0       (Y0),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .ADDR_W   (ADDR_W),
    .PREFETCH (PREFETCH),
    .H_TOTAL  (H_TOTAL_DEF)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .pixel_en (pixel_en),
    .x        (x),
    .y        (y),
    .mem_addr (mem_addr)
  );

endmodule

// File: tb/tb_quadrant_view_ctrl.sv
// Self-checking bench for quadrant_view_ctrl: address sweep against pixel
// arithmetic, quadrant browsing with wrap, handshake and reset abort.
module tb_quadrant_view_ctrl;

  localparam int X0 = 20;
  localparam int Y0 = 40;
  localparam int W  = 400;
  localparam int H  = 400;

  logic        clk = 1'b0;
  logic        reset, pixel_en, btn_next, btn_prev, btn_go, proc_ack, proc_done;
  logic [9:0]  x, y;
  logic [4:0]  quadrant, proc_quadrant;
  logic        start, proc_req, busy;
  logic [17:0] mem_addr;

  int checks   = 0;
  int failures = 0;
  int exp_addr = 0;
  int exp_q    = 1;

  always #5 clk = ~clk;

  quadrant_view_ctrl dut (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .x(x), .y(y),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_go(btn_go),
    .proc_ack(proc_ack), .proc_done(proc_done),
    .quadrant(quadrant), .start(start), .proc_req(proc_req),
    .proc_quadrant(proc_quadrant), .mem_addr(mem_addr), .busy(busy)
  );

  // Quadrant arithmetic straight from the 1..16 wrap rule.
  function automatic int q_model(input int q, input int d);
    return ((q - 1 + d + 32) % 16) + 1;
  endfunction

  // One pixel tick; the address model is the pixel's linear image index.
  task automatic pix_tick(input int px, input int py);
    int xa;
    @(negedge clk);
    x = 10'(px); y = 10'(py); pixel_en = 1'b1;
    @(negedge clk);
    pixel_en = 1'b0;
    x = 10'($urandom_range(0, 799));
    y = 10'($urandom_range(0, 524));
    xa = px + 1;
    if (xa >= X0 && xa < X0 + W && py >= Y0 && py < Y0 + H)
      exp_addr = (py - Y0) * W + (xa - X0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: btn_next = 1'b1;
      1: btn_prev = 1'b1;
      default: btn_go = 1'b1;
    endcase
    repeat ($urandom_range(1, 4)) @(negedge clk);
    btn_next = 1'b0; btn_prev = 1'b0; btn_go = 1'b0;
    repeat (3) @(negedge clk);
    $display("press %s", (which == 0) ? "next" : (which == 1) ? "prev" : "go");
  endtask

  task automatic pulse_proc(input logic ack, input logic done);
    @(negedge clk);
    proc_ack = ack; proc_done = done;
    @(negedge clk);
    proc_ack = 1'b0; proc_done = 1'b0;
    $display("proc pulse ack=%0b done=%0b", ack, done);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (quadrant !== 5'd1) begin failures++; $display("FAIL rst_quadrant got=%0d exp=1", quadrant); end
    if (start !== 1'b0) begin failures++; $display("FAIL rst_start got=%0b exp=0", start); end
    if (proc_req !== 1'b0) begin failures++; $display("FAIL rst_proc_req got=%0b exp=0", proc_req); end
    if (proc_quadrant !== 5'd1) begin failures++; $display("FAIL rst_proc_quadrant got=%0d exp=1", proc_quadrant); end
    if (mem_addr !== 18'd0) begin failures++; $display("FAIL rst_mem_addr got=%0d exp=0", mem_addr); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    reset = 1'b0;
    exp_addr = 0; exp_q = 1;
    repeat (2) @(negedge clk);
    $display("reset applied and released");
  endtask

  task automatic test_addr();
    int bnd;
    pix_tick(0, 0);
    checks += 3;
    if (quadrant !== 5'd1) begin failures++; $display("FAIL frame1_quadrant got=%0d exp=1", quadrant); end
    if (start !== 1'b0) begin failures++; $display("FAIL frame1_start got=%0b exp=0", start); end
    if (proc_req !== 1'b0) begin failures++; $display("FAIL frame1_proc_req got=%0b exp=0", proc_req); end
    for (int py = Y0; py < Y0 + H; py++) begin
      checks++;
      if (mem_addr !== 18'(exp_addr)) begin
        failures++; $display("FAIL addr_linestart(0,%0d) got=%0d exp=%0d", py, mem_addr, exp_addr);
      end
      pix_tick(0, py);
      if (py < Y0 + 2 || py == Y0 + H - 1) begin
        for (int px = 15; px <= 425; px++) begin
          checks++;
          if (mem_addr !== 18'(exp_addr)) begin
            failures++; $display("FAIL addr(%0d,%0d) got=%0d exp=%0d", px, py, mem_addr, exp_addr);
          end
          bnd = -1;
          if (px == 20 && py == 40) bnd = 0;
          if (px == 419 && py == 40) bnd = 399;
          if (px == 20 && py == 41) bnd = 400;
          if (px >= 419 && py == 439) bnd = 159999;
          if (bnd >= 0) begin
            checks++;
            if (mem_addr !== 18'(bnd)) begin
              failures++; $display("FAIL addr_boundary(%0d,%0d) got=%0d exp=%0d", px, py, mem_addr, bnd);
            end
          end
          pix_tick(px, py);
        end
        $display("line %0d swept, mem_addr=%0d", py, mem_addr);
      end
    end
  endtask

  task automatic test_browse();
    int n, d;
    repeat (3) press(0);
    exp_q = q_model(exp_q, 3);
    checks++;
    if (quadrant !== 5'd1) begin failures++; $display("FAIL q_before_frame got=%0d exp=1", quadrant); end
    pix_tick(0, 0);
    checks++;
    if (quadrant !== 5'(exp_q)) begin failures++; $display("FAIL q_next3 got=%0d exp=%0d", quadrant, exp_q); end
    repeat (3) press(1);
    exp_q = q_model(exp_q, -3);
    pix_tick(0, 0);
    checks++;
    if (quadrant !== 5'd1) begin failures++; $display("FAIL q_back_to_1 got=%0d exp=1", quadrant); end
    press(1);
    exp_q = q_model(exp_q, -1);
    pix_tick(0, 0);
    checks++;
    if (quadrant !== 5'd16) begin failures++; $display("FAIL q_prev_wrap got=%0d exp=16", quadrant); end
    @(negedge clk); btn_next = 1'b1;
    repeat (25) @(negedge clk);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
    exp_q = q_model(exp_q, 1);
    pix_tick(0, 0);
    checks++;
    if (quadrant !== 5'd1) begin failures++; $display("FAIL q_held_next got=%0d exp=1", quadrant); end
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        d = $urandom_range(0, 1);
        press(d);
        exp_q = q_model(exp_q, (d == 0) ? 1 : -1);
      end
      pix_tick(0, 0);
      checks++;
      if (quadrant !== 5'(exp_q)) begin failures++; $display("FAIL q_random%0d got=%0d exp=%0d", r, quadrant, exp_q); end
    end
  endtask

  task automatic test_handshake();
    int steps, t;
    steps = (7 - exp_q + 16) % 16;
    repeat (steps) press(0);
    exp_q = 7;
    pix_tick(0, 0);
    checks++;
    if (quadrant !== 5'd7) begin failures++; $display("FAIL hs_q7 got=%0d exp=7", quadrant); end
    press(2);
    t = 0;
    while (proc_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks += 3;
    if (proc_req !== 1'b1) begin failures++; $display("FAIL hs_req got=%0b exp=1", proc_req); end
    if (proc_quadrant !== 5'd7) begin failures++; $display("FAIL hs_proc_q got=%0d exp=7", proc_quadrant); end
    if (busy !== 1'b1) begin failures++; $display("FAIL hs_busy_req got=%0b exp=1", busy); end
    press(0);
    checks++;
    if (proc_req !== 1'b1) begin failures++; $display("FAIL hs_req_hold got=%0b exp=1", proc_req); end
    pulse_proc(1'b1, 1'b0);
    checks += 2;
    if (proc_req !== 1'b0) begin failures++; $display("FAIL hs_ack_req got=%0b exp=0", proc_req); end
    if (busy !== 1'b1) begin failures++; $display("FAIL hs_wait_busy got=%0b exp=1", busy); end
    repeat ($urandom_range(2, 8)) @(negedge clk);
    pulse_proc(1'b0, 1'b1);
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL hs_done_busy got=%0b exp=0", busy); end
    if (start !== 1'b0) begin failures++; $display("FAIL hs_start_early got=%0b exp=0", start); end
    pix_tick(0, 0);
    checks += 2;
    if (start !== 1'b1) begin failures++; $display("FAIL hs_start got=%0b exp=1", start); end
    if (quadrant !== 5'd7) begin failures++; $display("FAIL hs_q_show got=%0d exp=7", quadrant); end
    press(2);
    checks++;
    if (start !== 1'b1) begin failures++; $display("FAIL hs_start_hold got=%0b exp=1", start); end
    pix_tick(0, 0);
    checks += 2;
    if (start !== 1'b0) begin failures++; $display("FAIL hs_start_back got=%0b exp=0", start); end
    if (quadrant !== 5'd7) begin failures++; $display("FAIL hs_q_back got=%0d exp=7", quadrant); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    btn_next = 1'b1; btn_go = 1'b1;
    repeat (2) @(negedge clk);
    btn_next = 1'b0; btn_go = 1'b0;
    repeat (3) @(negedge clk);
    $display("press next+go together");
    checks += 2;
    if (proc_req !== 1'b1) begin failures++; $display("FAIL sc_req got=%0b exp=1", proc_req); end
    if (proc_quadrant !== 5'd7) begin failures++; $display("FAIL sc_proc_q got=%0d exp=7", proc_quadrant); end
    pix_tick(0, 0);
    checks++;
    if (quadrant !== 5'd7) begin failures++; $display("FAIL sc_quadrant got=%0d exp=7", quadrant); end
    pulse_proc(1'b1, 1'b1);
    checks += 2;
    if (proc_req !== 1'b0) begin failures++; $display("FAIL sc_ackdone_req got=%0b exp=0", proc_req); end
    if (busy !== 1'b0) begin failures++; $display("FAIL sc_ackdone_busy got=%0b exp=0", busy); end
    pix_tick(0, 0);
    checks++;
    if (start !== 1'b1) begin failures++; $display("FAIL sc_start got=%0b exp=1", start); end
    press(2);
    pix_tick(0, 0);
    checks++;
    if (start !== 1'b0) begin failures++; $display("FAIL sc_start_back got=%0b exp=0", start); end
  endtask

  task automatic test_reset_wait();
    int t;
    press(2);
    t = 0;
    while (proc_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    pulse_proc(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rw_busy got=%0b exp=1", busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_addr = 0; exp_q = 1;
    checks += 6;
    if (quadrant !== 5'd1) begin failures++; $display("FAIL rw_quadrant got=%0d exp=1", quadrant); end
    if (start !== 1'b0) begin failures++; $display("FAIL rw_start got=%0b exp=0", start); end
    if (proc_req !== 1'b0) begin failures++; $display("FAIL rw_proc_req got=%0b exp=0", proc_req); end
    if (proc_quadrant !== 5'd1) begin failures++; $display("FAIL rw_proc_q got=%0d exp=1", proc_quadrant); end
    if (mem_addr !== 18'd0) begin failures++; $display("FAIL rw_mem_addr got=%0d exp=0", mem_addr); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rw_busy_rst got=%0b exp=0", busy); end
    @(negedge clk);
    reset = 1'b0;
    $display("reset asserted in wait");
    pulse_proc(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL rw_late_done_busy got=%0b exp=0", busy); end
    if (proc_req !== 1'b0) begin failures++; $display("FAIL rw_late_done_req got=%0b exp=0", proc_req); end
    pix_tick(0, 0);
    checks += 2;
    if (start !== 1'b0) begin failures++; $display("FAIL rw_late_done_start got=%0b exp=0", start); end
    if (quadrant !== 5'd1) begin failures++; $display("FAIL rw_late_done_q got=%0d exp=1", quadrant); end
    press(2);
    t = 0;
    while (proc_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (proc_req !== 1'b1) begin failures++; $display("FAIL rr_req got=%0b exp=1", proc_req); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (proc_req !== 1'b0) begin failures++; $display("FAIL rr_async_drop got=%0b exp=0", proc_req); end
    @(negedge clk);
    reset = 1'b0;
    $display("reset asserted in req");
  endtask

  initial begin
    reset = 1'b1; pixel_en = 1'b0; x = '0; y = '0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_go = 1'b0;
    proc_ack = 1'b0; proc_done = 1'b0;
    test_reset();
    test_addr();
    test_browse();
    test_handshake();
    test_same_cycle();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
